rs_age_ordered: RTL

Parametrised reservation station for the out-of-order core, sitting between the issue stage and the ALU. It holds renamed ALU instructions until both operands are available and snoops any number of result broadcast (CDB) channels. It dispatches the oldest ready entry through a valid/ready handshake with backpressure. It generalises the current fixed-size, two-broadcast, no-backpressure RS.

---
 rtl/rs_age_ordered_if.sv | 62 ++++++
 rtl/rs_age_ordered.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_ordered_if.sv
// Issue, CDB snoop and ALU dispatch bundle for the age-ordered reservation station.
// The slave side is the RS; the master side is the issue stage / CDB / ALU environment.
interface rs_age_ordered_if #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned OP_W    = 7,
    parameter int unsigned F3_W    = 3
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                     issue_valid;
    logic                     issue_ready;
    logic [XLEN-1:0]          issue_rs1_val;
    logic [XLEN-1:0]          issue_rs2_val;
    logic                     issue_rs1_busy;
    logic                     issue_rs2_busy;
    logic [ROB_W-1:0]         issue_rs1_tag;
    logic [ROB_W-1:0]         issue_rs2_tag;
    logic [XLEN-1:0]          issue_imm;
    logic [XLEN-1:0]          issue_pc;
    logic [OP_W-1:0]          issue_opcode;
    logic [F3_W-1:0]          issue_funct3;
    logic                     issue_funct7;
    logic [ROB_W-1:0]         issue_rob_pos;

    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*ROB_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_val;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [XLEN-1:0]          alu_val1;
    logic [XLEN-1:0]          alu_val2;
    logic [XLEN-1:0]          alu_imm;
    logic [XLEN-1:0]          alu_pc;
    logic [OP_W-1:0]          alu_opcode;
    logic [F3_W-1:0]          alu_funct3;
    logic                     alu_funct7;
    logic [ROB_W-1:0]         alu_rob_pos;

    logic [OCC_W-1:0]         occupancy;

    modport master (
        output issue_valid, issue_rs1_val, issue_rs2_val, issue_rs1_busy, issue_rs2_busy,
               issue_rs1_tag, issue_rs2_tag, issue_imm, issue_pc, issue_opcode,
               issue_funct3, issue_funct7, issue_rob_pos,
               cdb_valid, cdb_tag, cdb_val, alu_ready,
        input  issue_ready, alu_valid, alu_val1, alu_val2, alu_imm, alu_pc,
               alu_opcode, alu_funct3, alu_funct7, alu_rob_pos, occupancy
    );

    modport slave (
        input  issue_valid, issue_rs1_val, issue_rs2_val, issue_rs1_busy, issue_rs2_busy,
               issue_rs1_tag, issue_rs2_tag, issue_imm, issue_pc, issue_opcode,
               issue_funct3, issue_funct7, issue_rob_pos,
               cdb_valid, cdb_tag, cdb_val, alu_ready,
        output issue_ready, alu_valid, alu_val1, alu_val2, alu_imm, alu_pc,
               alu_opcode, alu_funct3, alu_funct7, alu_rob_pos, occupancy
    );
endinterface

// File: rtl/rs_age_ordered.sv
// ALU reservation station: holds renamed ops until operands arrive over the CDB,
// then dispatches the oldest ready entry (age matrix) through a registered valid/ready stage.
module rs_age_ordered #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned OP_W    = 7,
    parameter int unsigned F3_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rollback,
    rs_age_ordered_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid, busy1, busy2, funct7;
    logic [DEPTH-1:0] older [DEPTH];
    logic [ROB_W-1:0] tag1 [DEPTH];
    logic [ROB_W-1:0] tag2 [DEPTH];
    logic [ROB_W-1:0] rob_pos [DEPTH];
    logic [XLEN-1:0]  val1 [DEPTH];
    logic [XLEN-1:0]  val2 [DEPTH];
    logic [XLEN-1:0]  imm [DEPTH];
    logic [XLEN-1:0]  pc [DEPTH];
    logic [OP_W-1:0]  opcode [DEPTH];
    logic [F3_W-1:0]  funct3 [DEPTH];

    logic [NUM_CDB-1:0] c_vld;
    logic [ROB_W-1:0]   c_tag [NUM_CDB];
    logic [XLEN-1:0]    c_val [NUM_CDB];

    logic [DEPTH-1:0] ready, sel;
    logic             has_ready, out_free, dispatch, accept, found;
    logic [IDX_W-1:0] alloc_idx;
    logic             in_busy1, in_busy2;
    logic [XLEN-1:0]  in_val1, in_val2;

    logic [XLEN-1:0]  s_val1, s_val2, s_imm, s_pc;
    logic [OP_W-1:0]  s_opcode;
    logic [F3_W-1:0]  s_funct3;
    logic             s_funct7;
    logic [ROB_W-1:0] s_rob_pos;

    always_comb begin
        c_vld = bus.cdb_valid;
        for (int k = 0; k < NUM_CDB; k++) begin
            c_tag[k] = bus.cdb_tag[k*ROB_W +: ROB_W];
            c_val[k] = bus.cdb_val[k*XLEN +: XLEN];
        end
    end

    function automatic logic cdb_hit(input logic [ROB_W-1:0] t);
        logic h;
        h = 1'b0;
        for (int k = 0; k < NUM_CDB; k++)
            if (c_vld[k] && c_tag[k] == t) h = 1'b1;
        return h;
    endfunction

    // Scan high to low so the lowest matching channel wins.
    function automatic logic [XLEN-1:0] cdb_data(input logic [ROB_W-1:0] t);
        logic [XLEN-1:0] d;
        d = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--)
            if (c_vld[k] && c_tag[k] == t) d = c_val[k];
        return d;
    endfunction

    assign bus.issue_ready = (bus.occupancy < OCC_W'(DEPTH));

    // Oldest-ready select: an entry wins when no older entry is also ready.
    always_comb begin
        ready = valid & ~busy1 & ~busy2;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < DEPTH; j++)
                if (ready[j] && older[j][i]) sel[i] = 1'b0;
        end
        has_ready = |ready;
        out_free  = !bus.alu_valid || bus.alu_ready;
        dispatch  = out_free && has_ready;
        accept    = bus.issue_valid && bus.issue_ready;
    end

    always_comb begin
        alloc_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && !valid[i]) begin
                alloc_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
        in_busy1 = bus.issue_rs1_busy && !cdb_hit(bus.issue_rs1_tag);
        in_busy2 = bus.issue_rs2_busy && !cdb_hit(bus.issue_rs2_tag);
        in_val1  = bus.issue_rs1_busy ? cdb_data(bus.issue_rs1_tag) : bus.issue_rs1_val;
        in_val2  = bus.issue_rs2_busy ? cdb_data(bus.issue_rs2_tag) : bus.issue_rs2_val;
    end

    always_comb begin
        s_val1    = '0;
        s_val2    = '0;
        s_imm     = '0;
        s_pc      = '0;
        s_opcode  = '0;
        s_funct3  = '0;
        s_funct7  = 1'b0;
        s_rob_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                s_val1    = val1[i];
                s_val2    = val2[i];
                s_imm     = imm[i];
                s_pc      = pc[i];
                s_opcode  = opcode[i];
                s_funct3  = funct3[i];
                s_funct7  = funct7[i];
                s_rob_pos = rob_pos[i];
            end
        end
    end

    // Control state, age matrix and the dispatch register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid           <= '0;
            busy1           <= '0;
            busy2           <= '0;
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
            bus.alu_valid   <= 1'b0;
            bus.alu_val1    <= '0;
            bus.alu_val2    <= '0;
            bus.alu_imm     <= '0;
            bus.alu_pc      <= '0;
            bus.alu_opcode  <= '0;
            bus.alu_funct3  <= '0;
            bus.alu_funct7  <= 1'b0;
            bus.alu_rob_pos <= '0;
            bus.occupancy   <= '0;
        end else if (rdy) begin
            if (rollback) begin
                valid         <= '0;
                bus.alu_valid <= 1'b0;
                bus.occupancy <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy1[i] && cdb_hit(tag1[i])) busy1[i] <= 1'b0;
                    if (busy2[i] && cdb_hit(tag2[i])) busy2[i] <= 1'b0;
                    if (dispatch && sel[i]) valid[i] <= 1'b0;
                end
                if (accept) begin
                    valid[alloc_idx] <= 1'b1;
                    busy1[alloc_idx] <= in_busy1;
                    busy2[alloc_idx] <= in_busy2;
                    // New entry is younger than every currently valid entry.
                    for (int j = 0; j < DEPTH; j++) begin
                        older[alloc_idx][j] <= 1'b0;
                        older[j][alloc_idx] <= valid[j];
                    end
                end
                if (dispatch) begin
                    bus.alu_valid   <= 1'b1;
                    bus.alu_val1    <= s_val1;
                    bus.alu_val2    <= s_val2;
                    bus.alu_imm     <= s_imm;
                    bus.alu_pc      <= s_pc;
                    bus.alu_opcode  <= s_opcode;
                    bus.alu_funct3  <= s_funct3;
                    bus.alu_funct7  <= s_funct7;
                    bus.alu_rob_pos <= s_rob_pos;
                end else if (out_free) begin
                    bus.alu_valid <= 1'b0;
                end
                bus.occupancy <= bus.occupancy + OCC_W'(accept) - OCC_W'(dispatch);
            end
        end
    end

    // Entry payload: wakeup value capture and allocation writes.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !rollback) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy1[i] && cdb_hit(tag1[i])) val1[i] <= cdb_data(tag1[i]);
                if (busy2[i] && cdb_hit(tag2[i])) val2[i] <= cdb_data(tag2[i]);
            end
            if (accept) begin
                tag1[alloc_idx]    <= bus.issue_rs1_tag;
                tag2[alloc_idx]    <= bus.issue_rs2_tag;
                val1[alloc_idx]    <= in_val1;
                val2[alloc_idx]    <= in_val2;
                imm[alloc_idx]     <= bus.issue_imm;
                pc[alloc_idx]      <= bus.issue_pc;
                opcode[alloc_idx]  <= bus.issue_opcode;
                funct3[alloc_idx]  <= bus.issue_funct3;
                funct7[alloc_idx]  <= bus.issue_funct7;
                rob_pos[alloc_idx] <= bus.issue_rob_pos;
            end
        end
    end
endmodule
